issue_stage: RTL and testbench
==============================

// Module: issue_stage
// PURPOSE
//  Decode-to-execute issue stage. Takes decoded ops from the decoder, reads the regfile
//  and applies N-source operand forwarding. Resolves branches and jumps at issue and
//  redirects fetch. A per-register load scoreboard stalls only true load-use hazards.
//  Issued ops are held in a registered D/E latch with a valid/ready handshake.
// PARAMETERS
//  XLEN      64  datapath width
//  NFWD      3   forwarding sources; index 0 = youngest (E), highest priority
//  LOAD_LAT  2   cycles after issue before a load result is forwardable; range 1..7
//  CTLW      16  width of opaque control bundle passed through to execute
// PORTS
//  clk           in   1          clock, rising edge
//  resetn        in   1          asynchronous active-low reset
//  in_valid      in   1          decoded op present
//  in_ready      out  1          op accepted (or dropped) this cycle
//  in_pc         in   XLEN       op PC
//  in_ra1/in_ra2 in   5          source register numbers (0 = unused/x0)
//  in_rd         in   5          destination register
//  in_regwrite   in   1          op writes in_rd
//  in_memread    in   1          op is a load
//  in_useimm     in   1          srcb = in_imm instead of rs2
//  in_imm        in   XLEN       sign-extended immediate
//  in_br         in   4          0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR
//  in_ctl        in   CTLW       passthrough control
//  ra1/ra2       out  5          regfile read addresses, combinational = in_ra1/in_ra2
//  rd1/rd2       in   XLEN       regfile read data, same cycle
//  fwd_valid     in   NFWD       source i writes back a register
//  fwd_wa        in   5*NFWD     source i destination, slice [5i+4:5i]
//  fwd_data      in   XLEN*NFWD  source i result
//  out_valid     out  1          D/E latch holds an op
//  out_ready     in   1          execute accepts the latch this cycle
//  out_pc, out_srca, out_srcb, out_wd  out  XLEN  issued operands
//  out_rd        out  5          destination register
//  out_regwrite, out_memread  out  1  issued control
//  out_ctl       out  CTLW       issued passthrough control
//  redirect_valid out 1          fetch redirect, one-cycle pulse
//  redirect_pc   out  XLEN       redirect target
// BEHAVIOUR
//  Reset: out_valid=0, redirect_valid=0, every scoreboard counter=0, all out_* data=0.
//  Forwarding, per operand:
//   - Lowest index i with fwd_valid[i] && fwd_wa[i]==ra && ra!=0 supplies the value.
//   - Otherwise rd1/rd2 is used; ra==0 always yields 0.
//  Operands: srca=fwd(ra1); wd=fwd(ra2); srcb = in_useimm ? in_imm : wd.
//  Scoreboard: one 3-bit counter per register (x1..x31).
//   - hazard = in_valid && ((ra1!=0 && cnt[ra1]!=0) || (ra2!=0 && cnt[ra2]!=0)).
//  Acceptance:
//   - adv = !out_valid || out_ready.
//   - in_ready = redirect_valid || (adv && !hazard).
//   - fire = in_valid && in_ready && !redirect_valid.
//  Wrong-path drop: while redirect_valid=1, an incoming op is consumed (in_ready=1) and
//   discarded. Nothing is latched and the scoreboard is not touched.
//  Latch: on fire, out_* <= current op, out_valid <= 1. Otherwise, if out_ready, out_valid <= 0.
//  Counter update, each cycle:
//   - If fire && in_memread && in_regwrite && in_rd!=0: cnt[in_rd] <= LOAD_LAT.
//     Set wins over decrement for the same register.
//   - Otherwise a nonzero counter decrements when out_ready=1 and holds when out_ready=0.
//  Branch compare uses forwarded srca vs wd: BLT/BGE signed, BLTU/BGEU unsigned.
//   JAL/JALR always taken.
//  Target: in_pc+in_imm for branches and JAL; (srca+in_imm) & ~1 for JALR. Sums wrap modulo 2^XLEN.
//  Redirect: a taken op that fires sets redirect_valid <= 1 and redirect_pc <= target on the
//   next edge. redirect_valid drops the following cycle, so it is a single-cycle pulse.
//   A stalled branch does not redirect until it fires.
//  in_br values 9..15 are treated as NONE.
//  Reset asserted mid-operation clears the latch, redirect and scoreboard immediately;
//   the in-flight op is lost.
// TESTING
//  1. ADD x3 after issued LD x3 (LOAD_LAT=2, out_ready=1) -> in_ready=0 two cycles; ADD issues 3rd cycle.
//  2. fwd_valid=3'b011, fwd_wa both 5, data 0xA/0xB, ra1=5 -> out_srca=0xA; ra1=0 -> out_srca=0.
//  3. BEQ pc=0x100 imm=0x20, srca==wd=7 -> redirect_valid 1 cycle, redirect_pc=0x120; next op dropped.
//  4. BLT srca=-1, wd=1 -> taken; BLTU same operands -> not taken, no redirect.
//  5. out_ready=0 with latch full -> in_ready=0, out_* stable, load counters frozen.
//  6. JALR srca=0x1003, imm=0 -> redirect_pc=0x1002; resetn low mid-stall -> out_valid=0, counters 0.

Source files
------------

// File: rtl/issue_stage.sv
// Decode-to-execute issue stage: regfile read, N-source forwarding, load-use scoreboard,
// branch/jump resolution with fetch redirect, and a registered D/E latch with valid/ready.
module issue_stage #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NFWD     = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CTLW     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [4:0]           in_ra1,
    input  logic [4:0]           in_ra2,
    input  logic [4:0]           in_rd,
    input  logic                 in_regwrite,
    input  logic                 in_memread,
    input  logic                 in_useimm,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [3:0]           in_br,
    input  logic [CTLW-1:0]      in_ctl,
    output logic [4:0]           ra1,
    output logic [4:0]           ra2,
    input  logic [XLEN-1:0]      rd1,
    input  logic [XLEN-1:0]      rd2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [5*NFWD-1:0]    fwd_wa,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_srca,
    output logic [XLEN-1:0]      out_srcb,
    output logic [XLEN-1:0]      out_wd,
    output logic [4:0]           out_rd,
    output logic                 out_regwrite,
    output logic                 out_memread,
    output logic [CTLW-1:0]      out_ctl,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc
);

    localparam logic [3:0] BrBeq  = 4'd1;
    localparam logic [3:0] BrBne  = 4'd2;
    localparam logic [3:0] BrBlt  = 4'd3;
    localparam logic [3:0] BrBge  = 4'd4;
    localparam logic [3:0] BrBltu = 4'd5;
    localparam logic [3:0] BrBgeu = 4'd6;
    localparam logic [3:0] BrJal  = 4'd7;
    localparam logic [3:0] BrJalr = 4'd8;

    logic [2:0]      r_cnt [32];
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc, r_out_srca, r_out_srcb, r_out_wd;
    logic [4:0]      r_out_rd;
    logic            r_out_regwrite, r_out_memread;
    logic [CTLW-1:0] r_out_ctl;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic [XLEN-1:0] w_srca, w_wd, w_srcb, w_jalr_sum, w_target;
    logic            w_hazard, w_adv, w_fire, w_taken, w_lt_s, w_lt_u;

    // Lowest-index matching source wins; x0 always reads as zero.
    function automatic logic [XLEN-1:0] f_fwd(input logic [4:0] ra, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] v;
        logic            found;
        v     = rf;
        found = 1'b0;
        for (int i = 0; i < int'(NFWD); i++) begin
            if (!found && fwd_valid[i] && fwd_wa[5*i +: 5] == ra) begin
                v     = fwd_data[XLEN*i +: XLEN];
                found = 1'b1;
            end
        end
        if (ra == 5'd0) v = '0;
        return v;
    endfunction

    assign ra1    = in_ra1;
    assign ra2    = in_ra2;
    assign w_srca = f_fwd(in_ra1, rd1);
    assign w_wd   = f_fwd(in_ra2, rd2);
    assign w_srcb = in_useimm ? in_imm : w_wd;

    assign w_hazard = in_valid && ((in_ra1 != 5'd0 && r_cnt[in_ra1] != 3'd0) ||
                                   (in_ra2 != 5'd0 && r_cnt[in_ra2] != 3'd0));
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = r_redirect_valid || (w_adv && !w_hazard);
    assign w_fire   = in_valid && in_ready && !r_redirect_valid;

    assign w_lt_s     = $signed(w_srca) < $signed(w_wd);
    assign w_lt_u     = w_srca < w_wd;
    assign w_jalr_sum = w_srca + in_imm;
    assign w_target   = (in_br == BrJalr) ? {w_jalr_sum[XLEN-1:1], 1'b0} : in_pc + in_imm;

    always_comb begin
        w_taken = 1'b0;
        case (in_br)
            BrBeq:         w_taken = (w_srca == w_wd);
            BrBne:         w_taken = (w_srca != w_wd);
            BrBlt:         w_taken = w_lt_s;
            BrBge:         w_taken = !w_lt_s;
            BrBltu:        w_taken = w_lt_u;
            BrBgeu:        w_taken = !w_lt_u;
            BrJal, BrJalr: w_taken = 1'b1;
            default:       w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid      <= 1'b0;
            r_out_pc         <= '0;
            r_out_srca       <= '0;
            r_out_srcb       <= '0;
            r_out_wd         <= '0;
            r_out_rd         <= '0;
            r_out_regwrite   <= 1'b0;
            r_out_memread    <= 1'b0;
            r_out_ctl        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid    <= 1'b1;
                r_out_pc       <= in_pc;
                r_out_srca     <= w_srca;
                r_out_srcb     <= w_srcb;
                r_out_wd       <= w_wd;
                r_out_rd       <= in_rd;
                r_out_regwrite <= in_regwrite;
                r_out_memread  <= in_memread;
                r_out_ctl      <= in_ctl;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_redirect_valid <= w_fire && w_taken;
            if (w_fire && w_taken) r_redirect_pc <= w_target;
        end
    end

    // Counters only age while execute drains; a fresh load on the same register wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_fire && in_memread && in_regwrite && in_rd == 5'(i)) begin
                    r_cnt[i] <= 3'(LOAD_LAT);
                end else if (r_cnt[i] != 3'd0 && out_ready) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_pc         = r_out_pc;
    assign out_srca       = r_out_srca;
    assign out_srcb       = r_out_srcb;
    assign out_wd         = r_out_wd;
    assign out_rd         = r_out_rd;
    assign out_regwrite   = r_out_regwrite;
    assign out_memread    = r_out_memread;
    assign out_ctl        = r_out_ctl;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_issue_stage;

    localparam int XLEN     = 64;
    localparam int NFWD     = 3;
    localparam int LOAD_LAT = 2;
    localparam int CTLW     = 16;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 in_valid, in_ready;
    logic [XLEN-1:0]      in_pc, in_imm;
    logic [4:0]           in_ra1, in_ra2, in_rd;
    logic                 in_regwrite, in_memread, in_useimm;
    logic [3:0]           in_br;
    logic [CTLW-1:0]      in_ctl;
    logic [4:0]           ra1, ra2;
    logic [XLEN-1:0]      rd1, rd2;
    logic [NFWD-1:0]      fwd_valid;
    logic [5*NFWD-1:0]    fwd_wa;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic                 out_valid, out_ready;
    logic [XLEN-1:0]      out_pc, out_srca, out_srcb, out_wd;
    logic [4:0]           out_rd;
    logic                 out_regwrite, out_memread;
    logic [CTLW-1:0]      out_ctl;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]      t_fwa  [NFWD];
    logic [XLEN-1:0] t_fdat [NFWD];

    issue_stage #(.XLEN(XLEN), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT), .CTLW(CTLW)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_useimm(in_useimm), .in_imm(in_imm), .in_br(in_br),
        .in_ctl(in_ctl), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .fwd_valid(fwd_valid),
        .fwd_wa(fwd_wa), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_srca(out_srca), .out_srcb(out_srcb), .out_wd(out_wd),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_ctl(out_ctl), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 0; in_pc = '0; in_ra1 = '0; in_ra2 = '0; in_rd = '0;
        in_regwrite = 0; in_memread = 0; in_useimm = 0; in_imm = '0; in_br = '0;
        in_ctl = '0; rd1 = '0; rd2 = '0; fwd_valid = '0; fwd_wa = '0; fwd_data = '0;
        out_ready = 1;
    endtask

    task automatic drive_op(input logic [XLEN-1:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] dst, input logic rw, input logic mr,
                            input logic [XLEN-1:0] imm, input logic [3:0] br);
        in_valid = 1; in_pc = pc; in_ra1 = a1; in_ra2 = a2; in_rd = dst;
        in_regwrite = rw; in_memread = mr; in_useimm = 0; in_imm = imm; in_br = br;
        in_ctl = 16'($urandom);
    endtask

    task automatic test_reset;
        idle();
        resetn = 0;
        tick(); tick();
        n_tests++;
        if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valids got out_valid=%0b redirect_valid=%0b want 0/0",
                               out_valid, redirect_valid);
        end
        n_tests++;
        if ({out_pc, out_srca, out_srcb, out_wd, out_rd, out_ctl} !== '0) begin
            n_fail++; $display("FAIL reset_data got pc=%h srca=%h want 0", out_pc, out_srca);
        end
        #2 resetn = 1;
        tick();
    endtask

    task automatic test_load_use;
        int stalls = 0;
        drive_op(64'h10, 5'd0, 5'd0, 5'd3, 1, 1, '0, 4'd0);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ld_accept got in_ready=%0b want 1", in_ready);
        end
        tick();
        drive_op(64'h14, 5'd3, 5'd0, 5'd4, 1, 0, '0, 4'd0);
        #1;
        for (int c = 0; c < 8; c++) begin
            if (in_ready) break;
            stalls++;
            tick();
        end
        n_tests++;
        if (stalls != 2) begin
            n_fail++; $display("FAIL load_use_stalls got %0d want 2", stalls);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_pc !== 64'h14) begin
            n_fail++; $display("FAIL load_use_issue got valid=%0b rd=%0d pc=%h want 1/4/14",
                               out_valid, out_rd, out_pc);
        end
        idle();
        tick();
    endtask

    task automatic test_forwarding;
        logic [NFWD-1:0] fv  [5] = '{3'b011, 3'b011, 3'b010, 3'b000, 3'b100};
        logic [4:0]      a1  [5] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd5};
        logic [XLEN-1:0] exp [5] = '{64'hA, 64'h0, 64'hB, 64'h55, 64'hC};
        for (int k = 0; k < 5; k++) begin
            drive_op(64'h40, a1[k], 5'd5, 5'd0, 0, 0, 64'h77, 4'd0);
            in_useimm = 1;
            rd1 = 64'h55; rd2 = 64'h66;
            fwd_valid = fv[k];
            fwd_wa    = {5'd5, 5'd5, 5'd5};
            fwd_data  = {64'hC, 64'hB, 64'hA};
            tick();
            n_tests++;
            if (out_srca !== exp[k]) begin
                n_fail++; $display("FAIL fwd_srca_%0d got %h want %h", k, out_srca, exp[k]);
            end
        end
        n_tests++;
        if (out_srcb !== 64'h77 || out_wd !== 64'hC) begin
            n_fail++; $display("FAIL fwd_imm got srcb=%h wd=%h want 77/c", out_srcb, out_wd);
        end
        idle();
        tick();
    endtask

    task automatic test_branch_redirect;
        drive_op(64'h100, 5'd1, 5'd2, 5'd0, 0, 0, 64'h20, 4'd1);
        rd1 = 64'd7; rd2 = 64'd7;
        tick();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h120) begin
            n_fail++; $display("FAIL beq_redirect got v=%0b pc=%h want 1/120",
                               redirect_valid, redirect_pc);
        end
        drive_op(64'h104, 5'd0, 5'd0, 5'd6, 1, 1, '0, 4'd0);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drop_ready got %0b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drop_pulse got redirect=%0b out_valid=%0b want 0/0",
                               redirect_valid, out_valid);
        end
        drive_op(64'h108, 5'd6, 5'd0, 5'd0, 0, 0, '0, 4'd0);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drop_no_scoreboard got in_ready=%0b want 1", in_ready);
        end
        idle();
        tick();
    endtask

    task automatic test_signed_compare;
        drive_op(64'h200, 5'd1, 5'd2, 5'd0, 0, 0, 64'h40, 4'd3);
        rd1 = '1; rd2 = 64'd1;
        tick();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h240) begin
            n_fail++; $display("FAIL blt_taken got v=%0b pc=%h want 1/240",
                               redirect_valid, redirect_pc);
        end
        idle();
        tick();
        drive_op(64'h300, 5'd1, 5'd2, 5'd0, 0, 0, 64'h40, 4'd5);
        rd1 = '1; rd2 = 64'd1;
        tick();
        n_tests++;
        if (redirect_valid !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bltu_not_taken got redirect=%0b out_valid=%0b want 0/1",
                               redirect_valid, out_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        drive_op(64'h300, 5'd0, 5'd0, 5'd7, 1, 1, '0, 4'd0);
        tick();
        drive_op(64'h304, 5'd0, 5'd0, 5'd0, 0, 0, '0, 4'd0);
        out_ready = 0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready got %0b want 0", in_ready);
        end
        tick(); tick(); tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 64'h300 || out_memread !== 1'b1) begin
            n_fail++; $display("FAIL bp_stable got valid=%0b pc=%h want 1/300", out_valid, out_pc);
        end
        drive_op(64'h308, 5'd7, 5'd0, 5'd0, 0, 0, '0, 4'd0);
        out_ready = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_cnt_frozen got in_ready=%0b want 0", in_ready);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_cnt_one got in_ready=%0b want 0", in_ready);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_cnt_zero got in_ready=%0b want 1", in_ready);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_jalr_reset;
        drive_op(64'h400, 5'd1, 5'd0, 5'd0, 0, 0, 64'h0, 4'd8);
        rd1 = 64'h1003;
        tick();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1002) begin
            n_fail++; $display("FAIL jalr_target got v=%0b pc=%h want 1/1002",
                               redirect_valid, redirect_pc);
        end
        idle();
        tick();
        out_ready = 0;
        drive_op(64'h500, 5'd0, 5'd0, 5'd9, 1, 1, '0, 4'd0);
        tick();
        drive_op(64'h504, 5'd9, 5'd0, 5'd0, 0, 0, '0, 4'd0);
        tick();
        #2 resetn = 0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || out_pc !== '0) begin
            n_fail++; $display("FAIL midreset_clear got valid=%0b redirect=%0b pc=%h want 0",
                               out_valid, redirect_valid, out_pc);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_cnt got in_ready=%0b want 1", in_ready);
        end
        #1 resetn = 1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 64'h504) begin
            n_fail++; $display("FAIL post_reset_issue got valid=%0b pc=%h want 1/504",
                               out_valid, out_pc);
        end
        idle();
        tick();
    endtask

    function automatic logic [XLEN-1:0] m_fwd(input logic [4:0] ra, input logic [XLEN-1:0] rf);
        if (ra == 0) return '0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_valid[i] && t_fwa[i] == ra) return t_fdat[i];
        return rf;
    endfunction

    function automatic logic [XLEN-1:0] rnd_val();
        if ($urandom_range(0, 1) == 0) return 64'($urandom_range(0, 3));
        return {$urandom, $urandom};
    endfunction

    task automatic test_random;
        int              m_cnt [32];
        logic            m_ov, m_rv, exp_rdy, haz, fire, taken;
        logic [XLEN-1:0] m_rpc, a, b, tgt;
        logic [XLEN*4+5+2+CTLW-1:0] m_lat, got_lat;
        idle();
        resetn = 0;
        #2 resetn = 1;
        tick();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_ov = 0; m_rv = 0; m_rpc = '0; m_lat = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid    = ($urandom_range(0, 9) < 8);
            in_pc       = {$urandom, $urandom};
            in_ra1      = 5'($urandom_range(0, 3));
            in_ra2      = 5'($urandom_range(0, 3));
            in_rd       = 5'($urandom_range(0, 3));
            in_regwrite = 1'($urandom);
            in_memread  = ($urandom_range(0, 9) < 3);
            in_useimm   = 1'($urandom);
            in_imm      = rnd_val();
            in_br       = ($urandom_range(0, 9) < 5) ? 4'd0 : 4'($urandom_range(1, 15));
            in_ctl      = 16'($urandom);
            rd1         = rnd_val();
            rd2         = rnd_val();
            fwd_valid   = 3'($urandom);
            for (int i = 0; i < NFWD; i++) begin
                t_fwa[i]  = 5'($urandom_range(0, 3));
                t_fdat[i] = rnd_val();
                fwd_wa[5*i +: 5]         = t_fwa[i];
                fwd_data[XLEN*i +: XLEN] = t_fdat[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            a   = m_fwd(in_ra1, rd1);
            b   = m_fwd(in_ra2, rd2);
            haz = in_valid && ((in_ra1 != 0 && m_cnt[in_ra1] > 0) ||
                               (in_ra2 != 0 && m_cnt[in_ra2] > 0));
            exp_rdy = m_rv || ((!m_ov || out_ready) && !haz);
            fire    = in_valid && exp_rdy && !m_rv;
            n_tests++;
            if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_in_ready cyc=%0d got %0b want %0b",
                                   cyc, in_ready, exp_rdy);
            end
            case (in_br)
                4'd1: taken = (a == b);
                4'd2: taken = (a != b);
                4'd3: taken = ($signed(a) < $signed(b));
                4'd4: taken = !($signed(a) < $signed(b));
                4'd5: taken = (a < b);
                4'd6: taken = !(a < b);
                4'd7, 4'd8: taken = 1;
                default: taken = 0;
            endcase
            tgt = (in_br == 4'd8) ? ((a + in_imm) & ~64'd1) : (in_pc + in_imm);
            if (fire) begin
                m_ov  = 1;
                m_lat = {in_pc, a, in_useimm ? in_imm : b, b, in_rd, in_regwrite, in_memread,
                         in_ctl};
            end else if (out_ready) begin
                m_ov = 0;
            end
            m_rv = fire && taken;
            if (m_rv) m_rpc = tgt;
            for (int r = 1; r < 32; r++) begin
                if (fire && in_memread && in_regwrite && in_rd == 5'(r)) m_cnt[r] = LOAD_LAT;
                else if (m_cnt[r] > 0 && out_ready) m_cnt[r]--;
            end
            tick();
            got_lat = {out_pc, out_srca, out_srcb, out_wd, out_rd, out_regwrite, out_memread,
                       out_ctl};
            n_tests++;
            if (out_valid !== m_ov || got_lat !== m_lat) begin
                n_fail++; $display("FAIL rnd_latch cyc=%0d got v=%0b %h want v=%0b %h",
                                   cyc, out_valid, got_lat, m_ov, m_lat);
            end
            n_tests++;
            if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
                n_fail++; $display("FAIL rnd_redirect cyc=%0d got v=%0b pc=%h want v=%0b pc=%h",
                                   cyc, redirect_valid, redirect_pc, m_rv, m_rpc);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch_redirect();
        test_signed_compare();
        test_backpressure();
        test_jalr_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
